// File: rtl/ir_prefetch.sv
// Instruction register fed by a DEPTH-entry prefetch FIFO; head auto-promotes into the IR.
// Optional macro IR_BYPASS_EN: a push may load the IR directly when the queue is empty.
module ir_prefetch #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned OPC_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     load,
    input  logic                     flush,
    output logic [WIDTH-1:0]         data_out,
    output logic [OPC_W-1:0]         opcode,
    output logic [WIDTH-OPC_W-1:0]   operand,
    output logic                     ir_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_ir;
    logic             r_ir_valid;
    logic             r_full;
    logic             r_empty;
    logic             r_ovf;

    logic             w_want;
    logic             w_pop;
    logic             w_byp;
    logic             w_enq;
    logic             w_drop;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Refill is requested whenever the IR is consumed or holds nothing.
    assign w_want = load || !r_ir_valid;
    assign w_pop  = w_want && !r_empty && !flush;

`ifdef IR_BYPASS_EN
    assign w_byp  = w_want && r_empty && push && !flush;
`else
    assign w_byp  = 1'b0;
`endif

    // Acceptance uses the registered full flag; a same-edge pop never frees a slot.
    assign w_enq  = push && !r_full && !w_byp && !flush;
    assign w_drop = push && r_full && !flush;

    assign w_cnt_nxt = r_count + CNT_W'(w_enq) - CNT_W'(w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_ovf      <= 1'b0;
            r_ir_valid <= 1'b0;
            r_ir       <= '0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_ovf      <= 1'b0;
            r_ir_valid <= 1'b0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == CNT_W'(DEPTH));
            r_empty <= (w_cnt_nxt == '0);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_pop) begin
                r_ir       <= r_mem[r_rd_ptr];
                r_ir_valid <= 1'b1;
            end else if (w_byp) begin
                r_ir       <= push_data;
                r_ir_valid <= 1'b1;
            end else if (load) begin
                r_ir_valid <= 1'b0;
            end
        end
    end

    // Queue storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign data_out = r_ir;
    assign opcode   = r_ir[WIDTH-1 -: OPC_W];
    assign operand  = r_ir[WIDTH-OPC_W-1:0];
    assign ir_valid = r_ir_valid;
    assign count    = r_count;
    assign full     = r_full;
    assign empty    = r_empty;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_ir_prefetch.sv
// Directed bench for ir_prefetch with a queue-based reference model checked every cycle.
`timescale 1ns/1ps
module tb_ir_prefetch;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned OPC_W = 3;
`ifdef IR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   clk;
    logic                   rst_n;
    logic                   push;
    logic [WIDTH-1:0]       push_data;
    logic                   load;
    logic                   flush;
    logic [WIDTH-1:0]       data_out;
    logic [OPC_W-1:0]       opcode;
    logic [WIDTH-OPC_W-1:0] operand;
    logic                   ir_valid;
    logic [$clog2(DEPTH):0] count;
    logic                   full;
    logic                   empty;
    logic                   ovf;

    int total;
    int bad;

    ir_prefetch #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OPC_W(OPC_W)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data),
        .load(load), .flush(flush), .data_out(data_out), .opcode(opcode),
        .operand(operand), .ir_valid(ir_valid), .count(count), .full(full),
        .empty(empty), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an IR register plus a plain FIFO queue of words.
    int unsigned m_q[$];
    int unsigned m_ir;
    bit          m_valid;
    bit          m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_ir    = 0;
            m_valid = 0;
            m_ovf   = 0;
        end else if (flush) begin
            m_q.delete();
            m_valid = 0;
            m_ovf   = 0;
        end else begin
            bit was_full;
            bit taken;
            was_full = (m_q.size() == DEPTH);
            taken    = 0;
            if (load || !m_valid) begin
                if (m_q.size() > 0) begin
                    m_ir    = m_q.pop_front();
                    m_valid = 1;
                end else if (BYP && push) begin
                    m_ir    = push_data;
                    m_valid = 1;
                    taken   = 1;
                end else begin
                    m_valid = 0;
                end
            end
            if (push && !taken) begin
                if (was_full) m_ovf = 1;
                else          m_q.push_back(push_data);
            end
        end
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        int unsigned n;
        n = m_q.size();
        chk("data_out", data_out, m_ir);
        chk("opcode",   opcode,   m_ir >> (WIDTH - OPC_W));
        chk("operand",  operand,  m_ir & ((1 << (WIDTH - OPC_W)) - 1));
        chk("ir_valid", ir_valid, m_valid);
        chk("count",    count,    n);
        chk("full",     full,     n == DEPTH);
        chk("empty",    empty,    n == 0);
        chk("ovf",      ovf,      m_ovf);
    endtask

    // One clock: inputs already set; compare on the falling edge afterwards.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input bit p, input int unsigned d, input bit l, input bit f);
        push      = p;
        push_data = WIDTH'(d);
        load      = l;
        flush     = f;
    endtask

    task automatic push_seq(input int unsigned first, input int unsigned n);
        for (int i = 0; i < int'(n); i++) begin
            drive(1, first + i, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        @(negedge clk);
        compare_all();
        chk("rst_empty", empty, 1);
        chk("rst_data",  data_out, 0);
        rst_n = 1'b1;

        // Fill from empty
        drive(1, 'hA5, 0, 0);
        tick();
        if (BYP) begin
            chk("fill1_valid", ir_valid, 1);
            chk("fill1_count", count, 0);
        end else begin
            chk("fill1_valid", ir_valid, 0);
            chk("fill1_count", count, 1);
        end
        drive(0, 0, 0, 0);
        tick();
        chk("fill2_data",    data_out, 'hA5);
        chk("fill2_opcode",  opcode, 3'b101);
        chk("fill2_operand", operand, 5'b00101);
        chk("fill2_count",   count, 0);
        drive(0, 0, 1, 0);
        tick();
        chk("drain_valid", ir_valid, 0);
        chk("drain_held",  data_out, 'hA5);

        // Overflow
        push_seq('h11, 6);
        chk("ovf_ir",   data_out, 'h11);
        chk("ovf_full", full, 1);
        chk("ovf_flag", ovf, 1);
        chk("ovf_cnt",  count, 4);

        // Streaming, one word per cycle
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0);
            tick();
            chk("stream_data", data_out, (i < 4) ? ('h12 + i) : 'h15);
            chk("stream_valid", ir_valid, (i < 4) ? 1 : 0);
        end
        chk("stream_cnt", count, 0);

        // Simultaneous push + load at count 2
        push_seq('h21, 3);
        chk("sim_pre_cnt", count, 2);
        chk("sim_pre_ir",  data_out, 'h21);
        drive(1, 'h77, 1, 0);
        tick();
        chk("sim_ir",  data_out, 'h22);
        chk("sim_cnt", count, 2);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0);
            tick();
            if (i == 1) chk("sim_last", data_out, 'h77);
        end
        chk("sim_done_valid", ir_valid, 0);

        // Flush priority
        push_seq('h31, 4);
        chk("fl_pre_cnt", count, 3);
        chk("fl_pre_ovf", ovf, 1);
        drive(1, 'h99, 1, 1);
        tick();
        chk("fl_cnt",   count, 0);
        chk("fl_valid", ir_valid, 0);
        chk("fl_ovf",   ovf, 0);
        chk("fl_data",  data_out, 'h31);
        drive(0, 0, 0, 0);
        tick();
        chk("fl_absent", count, 0);

        // Asynchronous reset between edges
        push_seq('h41, 3);
        chk("ar_pre_cnt", count, 2);
        chk("ar_pre_valid", ir_valid, 1);
        drive(1, 'h55, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_data",  data_out, 0);
        chk("ar_valid", ir_valid, 0);
        chk("ar_count", count, 0);
        chk("ar_empty", empty, 1);
        chk("ar_full",  full, 0);
        chk("ar_ovf",   ovf, 0);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        drive(1, 'h51, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        tick();
        chk("ar_resume_data",  data_out, 'h51);
        chk("ar_resume_valid", ir_valid, 1);

        // Mixed traffic to exercise pointer wrap
        for (int i = 0; i < 24; i++) begin
            drive((i % 3) != 2, 'h60 + i, (i % 2) == 1, 0);
            tick();
        end
        drive(0, 0, 0, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
